// File: rtl/cd_config_bank.sv
// Multi-channel clock-enable divider bank with a valid/ready configuration port.
// Each channel loads new limits through a shadow register and switches over only at a counter wrap.
module cd_config_bank #(
  parameter int NUM_CH            = 4,
  parameter int WIDTH_CONFIG_ADDR = 4,
  parameter int WIDTH_LIMIT       = 16,
  parameter logic [NUM_CH*WIDTH_LIMIT-1:0] DEFAULT_LIMITS = {NUM_CH{16'd5207}}
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [WIDTH_CONFIG_ADDR-1:0]  c_addr,
  input  logic [WIDTH_LIMIT-1:0]        c_data,
  input  logic                          c_valid,
  output logic                          c_ready,
  output logic [NUM_CH-1:0]             c_done,
  output logic                          c_err,
  input  logic [NUM_CH-1:0]             ch_en,
  output logic [NUM_CH-1:0]             tick,
  output logic [NUM_CH-1:0]             pending,
  output logic [NUM_CH*WIDTH_LIMIT-1:0] limits
);

  logic [WIDTH_LIMIT-1:0] lim_q    [NUM_CH];
  logic [WIDTH_LIMIT-1:0] shadow_q [NUM_CH];
  logic [WIDTH_LIMIT-1:0] cnt_q    [NUM_CH];
  logic [NUM_CH-1:0]      pend_q;
  logic [NUM_CH-1:0]      tick_q;
  logic [NUM_CH-1:0]      done_q;
  logic                   err_q;

  logic                   addr_bcast;
  logic                   addr_legal;
  logic [NUM_CH-1:0]      addr_sel;
  logic                   accept;
  logic [NUM_CH-1:0]      load;
  logic [NUM_CH-1:0]      wrap;
  logic [NUM_CH-1:0]      apply;

  // Address decode and handshake; a channel with an unapplied value refuses further writes.
  always_comb begin
    addr_bcast = (c_addr == '0);
    addr_sel   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (c_addr == WIDTH_CONFIG_ADDR'(i + 1)) addr_sel[i] = 1'b1;
    end
    addr_legal = addr_bcast | (|addr_sel);
    if (addr_bcast)      c_ready = ~|pend_q;
    else if (addr_legal) c_ready = ~|(addr_sel & pend_q);
    else                 c_ready = 1'b1;
    accept = c_valid & c_ready;
    load   = '0;
    if (accept) load = addr_bcast ? {NUM_CH{1'b1}} : addr_sel;
  end

  // A held (disabled) counter sits at 0, so a pending value may be applied immediately.
  always_comb begin
    wrap  = '0;
    apply = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wrap[i]  = (cnt_q[i] == lim_q[i]);
      apply[i] = pend_q[i] & (~ch_en[i] | wrap[i]);
    end
  end

  // Shadow registers: data only, qualified by load.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (load[i]) shadow_q[i] <= c_data;
    end
  end

  // Counters, active limits and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      tick_q <= '0;
      done_q <= '0;
      err_q  <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
        lim_q[i] <= DEFAULT_LIMITS[i*WIDTH_LIMIT +: WIDTH_LIMIT];
      end
    end else begin
      err_q <= accept & ~addr_legal;
      for (int i = 0; i < NUM_CH; i++) begin
        tick_q[i] <= ch_en[i] & wrap[i];
        done_q[i] <= apply[i];
        pend_q[i] <= load[i] | (pend_q[i] & ~apply[i]);
        if (apply[i]) begin
          lim_q[i] <= shadow_q[i];
          cnt_q[i] <= '0;
        end else if (~ch_en[i] | wrap[i]) begin
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + WIDTH_LIMIT'(1);
        end
      end
    end
  end

  always_comb begin
    limits = '0;
    for (int i = 0; i < NUM_CH; i++) limits[i*WIDTH_LIMIT +: WIDTH_LIMIT] = lim_q[i];
  end

  assign tick    = tick_q;
  assign c_done  = done_q;
  assign c_err   = err_q;
  assign pending = pend_q;

endmodule

// File: tb/tb_cd_config_bank.sv
// Bench for cd_config_bank: directed sequences, a per-cycle reference model and pinned literal checks.
module tb_cd_config_bank;
  localparam int NCH = 4;
  localparam int AW  = 4;
  localparam int LW  = 16;
  localparam logic [NCH*LW-1:0] DEF = 64'h0006_0005_0004_0003;

  logic             clk = 1'b0;
  logic             rst;
  logic [AW-1:0]    c_addr;
  logic [LW-1:0]    c_data;
  logic             c_valid;
  logic             c_ready;
  logic [NCH-1:0]   c_done;
  logic             c_err;
  logic [NCH-1:0]   ch_en;
  logic [NCH-1:0]   tick;
  logic [NCH-1:0]   pending;
  logic [NCH*LW-1:0] limits;

  int n_checks = 0;
  int n_pass   = 0;

  cd_config_bank #(
    .NUM_CH(NCH), .WIDTH_CONFIG_ADDR(AW), .WIDTH_LIMIT(LW), .DEFAULT_LIMITS(DEF)
  ) dut (
    .clk(clk), .rst(rst), .c_addr(c_addr), .c_data(c_data), .c_valid(c_valid),
    .c_ready(c_ready), .c_done(c_done), .c_err(c_err), .ch_en(ch_en),
    .tick(tick), .pending(pending), .limits(limits)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: per-channel period position, active/staged limit and status pulses.
  logic [LW-1:0]  m_lim [NCH];
  logic [LW-1:0]  m_sh  [NCH];
  int             m_pos [NCH];
  logic [NCH-1:0] m_pend, m_tick, m_done;
  logic           m_err;

  function automatic logic model_ready(input logic [AW-1:0] a);
    if (a == 0) return (m_pend == 0);
    if (a <= NCH) return !m_pend[a-1];
    return 1'b1;
  endfunction

  function automatic logic [NCH*LW-1:0] model_limits();
    logic [NCH*LW-1:0] v;
    for (int i = 0; i < NCH; i++) v[i*LW +: LW] = m_lim[i];
    return v;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        m_lim[i] = DEF[i*LW +: LW];
        m_pos[i] = 0;
      end
      m_pend = '0; m_tick = '0; m_done = '0; m_err = 1'b0;
    end else begin
      logic acc, end_of_period;
      acc   = c_valid && model_ready(c_addr);
      m_err = acc && (c_addr > NCH);
      for (int i = 0; i < NCH; i++) begin
        end_of_period = ch_en[i] && (m_pos[i] == int'(m_lim[i]));
        m_tick[i] = end_of_period;
        m_done[i] = 1'b0;
        if (m_pend[i] && (!ch_en[i] || end_of_period)) begin
          m_lim[i]  = m_sh[i];
          m_pos[i]  = 0;
          m_pend[i] = 1'b0;
          m_done[i] = 1'b1;
        end else if (!ch_en[i]) begin
          m_pos[i] = 0;
        end else begin
          m_pos[i] = end_of_period ? 0 : m_pos[i] + 1;
        end
        if (acc && (c_addr == 0 || c_addr == AW'(i + 1))) begin
          m_sh[i]   = c_data;
          m_pend[i] = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("m_ready",   c_ready, model_ready(c_addr));
    chk("m_tick",    tick,    m_tick);
    chk("m_done",    c_done,  m_done);
    chk("m_err",     c_err,   m_err);
    chk("m_pending", pending, m_pend);
    chk("m_limits",  limits,  model_limits());
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NCH-1:0] seen;
    int ndone;
    rst = 1'b1; c_addr = '0; c_data = '0; c_valid = 1'b0; ch_en = '0;
    step(2);
    chk("rst_limits",  limits,  DEF);
    chk("rst_pending", pending, 4'h0);
    chk("rst_tick",    tick,    4'h0);
    chk("rst_ready",   c_ready, 1'b1);

    // Default limit 3 on ch0: ticks after edges 4 and 8.
    rst = 1'b0; ch_en = 4'b0001;
    step(3); chk("t1_tick_e3", tick[0], 1'b0);
    step(1); chk("t1_tick_e4", tick[0], 1'b1);
    chk("t1_lim0", limits[15:0], 16'd3);
    step(1); chk("t1_tick_e5", tick[0], 1'b0);
    step(3); chk("t1_tick_e8", tick[0], 1'b1);

    // Channel write while running: takes effect at the next wrap.
    step(1);
    c_addr = 4'd1; c_data = 16'd1; c_valid = 1'b1;
    chk("t2_ready_pre", c_ready, 1'b1);
    step(1); c_valid = 1'b0;
    chk("t2_pending", pending[0], 1'b1);
    chk("t2_ready_busy", c_ready, 1'b0);
    step(2);
    chk("t2_done", c_done, 4'b0001);
    chk("t2_lim0", limits[15:0], 16'd1);
    step(1); chk("t2_done_clr", c_done, 4'b0000); chk("t2_tick_a", tick[0], 1'b0);
    step(1); chk("t2_tick_b", tick[0], 1'b1);
    step(1); chk("t2_tick_c", tick[0], 1'b0);
    step(1); chk("t2_tick_d", tick[0], 1'b1);

    // Broadcast 0 to all channels at differing phases.
    ch_en = 4'hF;
    step(3);
    c_addr = 4'd0; c_data = 16'd0; c_valid = 1'b1;
    chk("t3_ready_pre", c_ready, 1'b1);
    step(1); c_valid = 1'b0;
    chk("t3_pending", pending, 4'hF);
    chk("t3_ready_busy", c_ready, 1'b0);
    seen = '0; ndone = 0;
    for (int k = 0; k < 12; k++) begin
      step(1);
      seen |= c_done;
      ndone += $countones(c_done);
    end
    chk("t3_seen", seen, 4'hF);
    chk("t3_ndone", ndone, 4);
    chk("t3_pend_clr", pending, 4'h0);
    chk("t3_ready_post", c_ready, 1'b1);
    chk("t3_tick_all", tick, 4'hF);
    chk("t3_limits", limits, 64'h0);

    // Illegal address.
    c_addr = 4'd7; c_data = 16'hABCD; c_valid = 1'b1;
    chk("t4_ready", c_ready, 1'b1);
    step(1); c_valid = 1'b0;
    chk("t4_err", c_err, 1'b1);
    chk("t4_pending", pending, 4'h0);
    chk("t4_limits", limits, 64'h0);
    step(1); chk("t4_err_clr", c_err, 1'b0);

    // Write to a disabled channel applies on the next edge.
    ch_en = 4'b1011; c_addr = 4'd3; c_data = 16'd9; c_valid = 1'b1;
    chk("t5_ready", c_ready, 1'b1);
    step(1); c_valid = 1'b0;
    chk("t5_pending", pending, 4'b0100);
    step(1);
    chk("t5_done", c_done, 4'b0100);
    chk("t5_lim2", limits[47:32], 16'd9);
    chk("t5_pend_clr", pending, 4'h0);
    ch_en = 4'hF;
    step(9); chk("t5_tick_9", tick[2], 1'b0);
    step(1); chk("t5_tick_10", tick[2], 1'b1);

    // Reset while a write is pending.
    c_addr = 4'd2; c_data = 16'd7; c_valid = 1'b1;
    step(1); c_valid = 1'b0;
    step(1);
    chk("t6_lim1", limits[31:16], 16'd7);
    chk("t6_done", c_done[1], 1'b1);
    step(2);
    c_data = 16'd2; c_valid = 1'b1;
    chk("t6_ready", c_ready, 1'b1);
    step(1); c_valid = 1'b0;
    chk("t6_pending", pending[1], 1'b1);
    rst = 1'b1;
    step(1);
    chk("t6_rst_pend", pending, 4'h0);
    chk("t6_rst_lim", limits, DEF);
    chk("t6_rst_done", c_done, 4'h0);
    chk("t6_rst_tick", tick, 4'h0);
    step(1); chk("t6_rst_done2", c_done, 4'h0);
    rst = 1'b0;
    step(5);
    chk("t6_post_done", c_done, 4'h0);

    @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
